vga_tile_painter: RTL and testbench

//  Tile framebuffer plus rectangle-fill engine feeding the VGA pixel-colour stage.
//  800x600 visible area, split into 100x75 tiles of 8x8 pixels, 3-bit RGB per tile.

---
 rtl/vga_tile_painter.sv | 184 ++++++++++++++++++
 tb/tb_vga_tile_painter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_painter.sv
// Tile framebuffer with a rectangle-fill engine on the write side and a
// one-cycle registered tile lookup on the VGA scan side.
module vga_tile_painter #(
    parameter int TILES_X   = 100,
    parameter int TILES_Y   = 75,
    parameter int TILE_LOG2 = 3
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [9:0] xcoord,
    input  logic [9:0] ycoord,
    input  logic       blank_in,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_x,
    input  logic [6:0] cmd_y,
    input  logic [6:0] cmd_w,
    input  logic [6:0] cmd_h,
    input  logic [2:0] cmd_color,
    output logic       busy,
    output logic       done,
    output logic [2:0] pix_color,
    output logic       blank_out
);

    localparam int DEPTH  = TILES_X * TILES_Y;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int TC_W   = 10 - TILE_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [6:0]        x_r, y_r, w_r, h_r;
    logic [2:0]        color_r;
    logic [6:0]        col_r, row_r;
    logic              load_s;
    logic              wr_en_s;
    logic              col_last_s, row_last_s;
    logic [7:0]        tile_x_s, tile_y_s;
    logic              tile_in_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [TC_W-1:0]   rd_col_s, rd_row_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              rd_valid_s;
    logic              cmd_ready_r, busy_r, done_r;
    logic [2:0]        pix_color_r;
    logic              blank_out_r;
    logic [2:0]        mem [0:DEPTH-1];

    // 8-bit sums so that a start near the edge plus a large span cannot wrap back on-screen
    assign tile_x_s   = {1'b0, x_r} + {1'b0, col_r};
    assign tile_y_s   = {1'b0, y_r} + {1'b0, row_r};
    assign tile_in_s  = (tile_x_s < 8'(TILES_X)) && (tile_y_s < 8'(TILES_Y));
    assign wr_addr_s  = ADDR_W'(tile_y_s[6:0]) * ADDR_W'(TILES_X) + ADDR_W'(tile_x_s[6:0]);
    assign col_last_s = (col_r == (w_r - 7'd1));
    assign row_last_s = (row_r == (h_r - 7'd1));

    assign rd_col_s   = xcoord[9:TILE_LOG2];
    assign rd_row_s   = ycoord[9:TILE_LOG2];
    assign rd_addr_s  = ADDR_W'(rd_row_s) * ADDR_W'(TILES_X) + ADDR_W'(rd_col_s);
    assign rd_valid_s = !blank_in && (xcoord != 10'h3FF) && (ycoord != 10'h3FF)
                        && (rd_col_s < TC_W'(TILES_X)) && (rd_row_s < TC_W'(TILES_Y));

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pix_color = pix_color_r;
    assign blank_out = blank_out_r;

    // Fill FSM state register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Fill FSM next-state, command load and tile write enable
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        wr_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    load_s = 1'b1;
                    if ((cmd_w == 7'd0) || (cmd_h == 7'd0)) begin
                        next_state_s = ST_FIN;
                    end else begin
                        next_state_s = ST_FILL;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                wr_en_s = tile_in_s;
                if (col_last_s && row_last_s) begin
                    next_state_s = ST_FIN;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_FIN: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Command latch and row-major tile walk (col innermost)
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= 7'd0;
            y_r     <= 7'd0;
            w_r     <= 7'd0;
            h_r     <= 7'd0;
            color_r <= 3'd0;
            col_r   <= 7'd0;
            row_r   <= 7'd0;
        end else if (load_s) begin
            x_r     <= cmd_x;
            y_r     <= cmd_y;
            w_r     <= cmd_w;
            h_r     <= cmd_h;
            color_r <= cmd_color;
            col_r   <= 7'd0;
            row_r   <= 7'd0;
        end else if (state_r == ST_FILL) begin
            if (col_last_s) begin
                col_r <= 7'd0;
                row_r <= row_r + 7'd1;
            end else begin
                col_r <= col_r + 7'd1;
            end
        end else begin
            col_r <= col_r;
        end
    end

    // Handshake/status outputs registered from the next state
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cmd_ready_r <= (next_state_s == ST_IDLE);
            busy_r      <= (next_state_s == ST_FILL);
            done_r      <= (next_state_s == ST_FIN);
        end
    end

    // Tile RAM write port; contents intentionally survive reset
    always_ff @(posedge sys_clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= color_r;
        end
    end

    // Scan read port; a same-cycle write to the same tile is seen one read later
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_color_r <= 3'd0;
            blank_out_r <= 1'b1;
        end else begin
            blank_out_r <= blank_in;
            if (rd_valid_s) begin
                pix_color_r <= mem[rd_addr_s];
            end else begin
                pix_color_r <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_tile_painter.sv
// Bench for vga_tile_painter: scan results go through an expectation queue,
// fill timing and tile contents are checked against a bench-side tile model.
module tb_vga_tile_painter;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [9:0] xcoord, ycoord;
    logic       blank_in;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_x, cmd_y, cmd_w, cmd_h;
    logic [2:0] cmd_color;
    logic       busy, done;
    logic [2:0] pix_color;
    logic       blank_out;

    vga_tile_painter dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .xcoord    (xcoord),
        .ycoord    (ycoord),
        .blank_in  (blank_in),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .pix_color (pix_color),
        .blank_out (blank_out)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] pix;
        logic       blk;
    } exp_t;

    typedef struct {
        int         x;
        int         y;
        logic       b;
        logic [2:0] c;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[10];
    logic [2:0] model [0:74][0:99];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act !== req) begin
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge sys_clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("scan(%0d,%0d) {pix,blank}", e.x, e.y),
                  32'({pix_color, blank_out}), 32'({e.pix, e.blk}));
        end
    endtask

    task automatic drive_pix(input int x, input int y, input logic b);
        exp_t e;
        xcoord   = 10'(x);
        ycoord   = 10'(y);
        blank_in = b;
        e.x   = x;
        e.y   = y;
        e.blk = b;
        if (b || x == 1023 || y == 1023 || (x >> 3) >= 100 || (y >> 3) >= 75) begin
            e.pix = 3'd0;
        end else begin
            e.pix = model[y >> 3][x >> 3];
        end
        exp_q.push_back(e);
    endtask

    task automatic idle_scan();
        xcoord   = 10'h3FF;
        ycoord   = 10'h3FF;
        blank_in = 1'b1;
    endtask

    task automatic model_fill(input int x, input int y, input int w, input int h, input logic [2:0] c);
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                if (x + k < 100 && y + r < 75) begin
                    model[y + r][x + k] = c;
                end
            end
        end
    endtask

    task automatic do_fill(input int x, input int y, input int w, input int h,
                           input logic [2:0] c, input int exp_cycles, input bit poke);
        int n;
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("cmd_ready before command", 32'(cmd_ready), 32'd1);
        cmd_x     = 7'(x);
        cmd_y     = 7'(y);
        cmd_w     = 7'(w);
        cmd_h     = 7'(h);
        cmd_color = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("cmd_ready low after accept", 32'(cmd_ready), 32'd0);
        n = 0;
        while (busy && n < 20000) begin
            if (poke && n == 2) begin
                cmd_valid = 1'b1;
                cmd_x     = 7'd0;
                cmd_y     = 7'd0;
                cmd_w     = 7'd1;
                cmd_h     = 7'd1;
                cmd_color = 3'b111;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        check($sformatf("fill %0dx%0d busy cycles", w, h), 32'(n), 32'(exp_cycles));
        check("done at fill end", 32'(done), 32'd1);
        tick();
        check("done is single pulse", 32'(done), 32'd0);
        check("cmd_ready back in idle", 32'(cmd_ready), 32'd1);
        model_fill(x, y, w, h, c);
    endtask

    task automatic verify_all();
        for (int r = 0; r < 75; r++) begin
            for (int k = 0; k < 100; k++) begin
                drive_pix(k * 8 + (k % 8), r * 8 + (r % 8), 1'b0);
                tick();
            end
        end
        idle_scan();
        tick();
    endtask

    initial begin
        // Expected values after ground colour 001 and a 4x2 fill of 100 at tile (2,3)
        vecs[0] = '{x: 16,   y: 24,   b: 1'b0, c: 3'b100};
        vecs[1] = '{x: 48,   y: 24,   b: 1'b0, c: 3'b001};
        vecs[2] = '{x: 47,   y: 39,   b: 1'b0, c: 3'b100};
        vecs[3] = '{x: 15,   y: 24,   b: 1'b0, c: 3'b001};
        vecs[4] = '{x: 16,   y: 40,   b: 1'b0, c: 3'b001};
        vecs[5] = '{x: 16,   y: 23,   b: 1'b0, c: 3'b001};
        vecs[6] = '{x: 20,   y: 30,   b: 1'b1, c: 3'b000};
        vecs[7] = '{x: 1023, y: 24,   b: 1'b0, c: 3'b000};
        vecs[8] = '{x: 16,   y: 1023, b: 1'b0, c: 3'b000};
        vecs[9] = '{x: 799,  y: 599,  b: 1'b0, c: 3'b001};

        for (int r = 0; r < 75; r++) begin
            for (int k = 0; k < 100; k++) begin
                model[r][k] = 3'b000;
            end
        end

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = 7'd0;
        cmd_y     = 7'd0;
        cmd_w     = 7'd0;
        cmd_h     = 7'd0;
        cmd_color = 3'd0;
        idle_scan();
        tick();
        tick();
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pix_color", 32'(pix_color), 32'd0);
        check("reset blank_out", 32'(blank_out), 32'd1);
        rst_n = 1'b1;
        tick();

        drive_pix(0, 0, 1'b1);
        tick();
        idle_scan();

        do_fill(0, 0, 100, 75, 3'b001, 7500, 1'b0);
        do_fill(2, 3, 4, 2, 3'b100, 8, 1'b0);

        for (int i = 0; i < 10; i++) begin
            drive_pix(vecs[i].x, vecs[i].y, vecs[i].b);
            check($sformatf("vector %0d model", i), 32'(exp_q[exp_q.size() - 1].pix), 32'(vecs[i].c));
            tick();
        end
        idle_scan();
        tick();

        do_fill(98, 74, 5, 3, 3'b011, 15, 1'b1);
        do_fill(0, 0, 0, 5, 3'b111, 0, 1'b0);
        verify_all();

        // Same-tile write and read in one cycle returns the old colour
        cmd_x     = 7'd10;
        cmd_y     = 7'd10;
        cmd_w     = 7'd1;
        cmd_h     = 7'd1;
        cmd_color = 3'b110;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("busy in single-tile fill", 32'(busy), 32'd1);
        drive_pix(80, 80, 1'b0);
        tick();
        check("done after single-tile fill", 32'(done), 32'd1);
        model[10][10] = 3'b110;
        drive_pix(80, 80, 1'b0);
        tick();
        idle_scan();
        tick();

        // Reset during the fourth cycle of a 4x4 fill
        cmd_x     = 7'd20;
        cmd_y     = 7'd20;
        cmd_w     = 7'd4;
        cmd_h     = 7'd4;
        cmd_color = 3'b101;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        check("busy before mid-fill reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-fill reset busy", 32'(busy), 32'd0);
        check("mid-fill reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid-fill reset done", 32'(done), 32'd0);
        check("mid-fill reset blank_out", 32'(blank_out), 32'd1);
        tick();
        check("no done during reset", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check("no done after reset release", 32'(done), 32'd0);
        check("idle after reset release", 32'(cmd_ready), 32'd1);
        model[20][20] = 3'b101;
        model[20][21] = 3'b101;
        model[20][22] = 3'b101;
        verify_all();

        // Raster sweep over row 0 with one distinct tile at column 5
        do_fill(5, 0, 1, 1, 3'b010, 1, 1'b0);
        for (int x = 0; x < 800; x++) begin
            drive_pix(x, 0, 1'b0);
            if (x >= 40 && x <= 47) begin
                check($sformatf("sweep model x=%0d", x), 32'(exp_q[exp_q.size() - 1].pix), 32'd2);
            end
            tick();
        end
        for (int x = 0; x < 16; x++) begin
            drive_pix(40 + x, 0, 1'b1);
            tick();
        end
        for (int x = 0; x < 8; x++) begin
            drive_pix(1023, 1023, 1'b1);
            tick();
        end
        idle_scan();
        tick();
        tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
